// File: rtl/ps2_ascii_kbd.sv
// ps2_ascii_kbd
// Turns the PS/2 set-2 scan-code byte stream into 7-bit uppercase ASCII key
// presses. The result is held in an Apple-II-style keyboard register for the 6502.
// The block tracks the break (F0) and extended (E0) prefixes and the Shift/Ctrl
// state. Presses are buffered so that a fast typist does not lose characters.
//
// Build option:
//   KBD_FIFO_EN  defined   -> FIFO of FIFO_DEPTH characters.
//                undefined -> a single holding register. A new character
//                             overwrites an unread one and sets overflow.
//
// Ports:
//   clock_50    in   1  system clock; all logic on the rising edge
//   res         in   1  synchronous active-high reset
//   scan_code   in   8  byte from the PS/2 receiver
//   scan_valid  in   1  one-cycle pulse per received byte
//   kbd_clr     in   1  one-cycle pulse that pops the current character
//   kbd         out  8  {key available, ASCII of head}; 0x00 when empty
//   kbd_strb    out  1  copy of kbd[7]
//   overflow    out  1  sticky: a character was dropped (cleared by res only)
//
// Latency: make code in cycle N -> character staged at N+1 -> visible on kbd at N+2.

module ps2_ascii_kbd #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clock_50,
    input  logic       res,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       kbd_clr,
    output logic [7:0] kbd,
    output logic       kbd_strb,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // {hit, ascii}: choose the unshifted or shifted character.
    function automatic logic [7:0] pick(input logic shift, input logic [6:0] lo,
                                        input logic [6:0] hi);
        return {1'b1, (shift ? hi : lo)};
    endfunction

    // Translate a make code to {hit, ascii}. hit=0 means the code is unmapped.
    function automatic logic [7:0] xlate(input logic [7:0] code, input logic ext,
                                         input logic shift);
        logic [7:0] r;
        r = 8'h00;
        if (ext) begin
            case (code)
                8'h6B:   r = {1'b1, 7'h08};   // left arrow acts as backspace
                8'h74:   r = {1'b1, 7'h15};   // right arrow = Ctrl-U
                8'h5A:   r = {1'b1, 7'h0D};   // keypad Enter
                default: r = 8'h00;
            endcase
        end else begin
            case (code)
                8'h1C: r = {1'b1, 7'h41};  8'h32: r = {1'b1, 7'h42};
                8'h21: r = {1'b1, 7'h43};  8'h23: r = {1'b1, 7'h44};
                8'h24: r = {1'b1, 7'h45};  8'h2B: r = {1'b1, 7'h46};
                8'h34: r = {1'b1, 7'h47};  8'h33: r = {1'b1, 7'h48};
                8'h43: r = {1'b1, 7'h49};  8'h3B: r = {1'b1, 7'h4A};
                8'h42: r = {1'b1, 7'h4B};  8'h4B: r = {1'b1, 7'h4C};
                8'h3A: r = {1'b1, 7'h4D};  8'h31: r = {1'b1, 7'h4E};
                8'h44: r = {1'b1, 7'h4F};  8'h4D: r = {1'b1, 7'h50};
                8'h15: r = {1'b1, 7'h51};  8'h2D: r = {1'b1, 7'h52};
                8'h1B: r = {1'b1, 7'h53};  8'h2C: r = {1'b1, 7'h54};
                8'h3C: r = {1'b1, 7'h55};  8'h2A: r = {1'b1, 7'h56};
                8'h1D: r = {1'b1, 7'h57};  8'h22: r = {1'b1, 7'h58};
                8'h35: r = {1'b1, 7'h59};  8'h1A: r = {1'b1, 7'h5A};
                8'h16: r = pick(shift, 7'h31, 7'h21);   // 1 !
                8'h1E: r = pick(shift, 7'h32, 7'h40);   // 2 @
                8'h26: r = pick(shift, 7'h33, 7'h23);   // 3 #
                8'h25: r = pick(shift, 7'h34, 7'h24);   // 4 $
                8'h2E: r = pick(shift, 7'h35, 7'h25);   // 5 %
                8'h36: r = pick(shift, 7'h36, 7'h5E);   // 6 ^
                8'h3D: r = pick(shift, 7'h37, 7'h26);   // 7 &
                8'h3E: r = pick(shift, 7'h38, 7'h2A);   // 8 *
                8'h46: r = pick(shift, 7'h39, 7'h28);   // 9 (
                8'h45: r = pick(shift, 7'h30, 7'h29);   // 0 )
                8'h0E: r = pick(shift, 7'h60, 7'h7E);   // ` ~
                8'h4E: r = pick(shift, 7'h2D, 7'h5F);   // - _
                8'h55: r = pick(shift, 7'h3D, 7'h2B);   // = +
                8'h54: r = pick(shift, 7'h5B, 7'h7B);   // [ {
                8'h5B: r = pick(shift, 7'h5D, 7'h7D);   // ] }
                8'h5D: r = pick(shift, 7'h5C, 7'h7C);   // \ |
                8'h4C: r = pick(shift, 7'h3B, 7'h3A);   // ; :
                8'h52: r = pick(shift, 7'h27, 7'h22);   // ' "
                8'h41: r = pick(shift, 7'h2C, 7'h3C);   // , <
                8'h49: r = pick(shift, 7'h2E, 7'h3E);   // . >
                8'h4A: r = pick(shift, 7'h2F, 7'h3F);   // / ?
                8'h29: r = {1'b1, 7'h20};  8'h5A: r = {1'b1, 7'h0D};
                8'h66: r = {1'b1, 7'h08};  8'h76: r = {1'b1, 7'h1B};
                8'h0D: r = {1'b1, 7'h09};
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    // Ctrl folds the 0x40-0x5F column down to control codes.
    function automatic logic [6:0] apply_ctrl(input logic ctrl, input logic [6:0] ch);
        return (ctrl && (ch[6:5] == 2'b10)) ? {2'b00, ch[4:0]} : ch;
    endfunction

    state_t     state_r, state_nxt_s;
    logic       is_make_s, is_break_s, is_ext_s;
    logic       lshift_r, rshift_r, lctrl_r, rctrl_r;
    logic       shift_s, ctrl_s, push_s;
    logic [7:0] xlate_s;
    logic [6:0] char_s;
    logic       push_req_r;
    logic [6:0] push_char_r;
    logic [7:0] kbd_r;
    logic       overflow_r;

    // Prefix FSM: next state plus classification of the current byte.
    always_comb begin
        state_nxt_s = state_r;
        is_make_s   = 1'b0;
        is_break_s  = 1'b0;
        is_ext_s    = 1'b0;
        if (scan_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (scan_code == 8'hF0) begin
                        state_nxt_s = ST_BRK;
                    end else if (scan_code == 8'hE0) begin
                        state_nxt_s = ST_EXT;
                    end else begin
                        is_make_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    is_break_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                ST_EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_nxt_s = ST_EXT_BRK;
                    end else begin
                        is_make_s   = 1'b1;
                        is_ext_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    is_break_s  = 1'b1;
                    is_ext_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Prefix FSM state register.
    always_ff @(posedge clock_50) begin
        if (res) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign shift_s = lshift_r | rshift_r;
    assign ctrl_s  = lctrl_r | rctrl_r;
    assign xlate_s = xlate(scan_code, is_ext_s, shift_s);
    assign char_s  = apply_ctrl(ctrl_s, xlate_s[6:0]);
    assign push_s  = is_make_s & xlate_s[7];

    // Modifier tracking: a make code sets the key, a break code clears it.
    always_ff @(posedge clock_50) begin
        if (res) begin
            lshift_r <= 1'b0;
            rshift_r <= 1'b0;
            lctrl_r  <= 1'b0;
            rctrl_r  <= 1'b0;
        end else if (is_make_s || is_break_s) begin
            if (!is_ext_s && (scan_code == 8'h12)) lshift_r <= is_make_s;
            if (!is_ext_s && (scan_code == 8'h59)) rshift_r <= is_make_s;
            if (!is_ext_s && (scan_code == 8'h14)) lctrl_r  <= is_make_s;
            if ( is_ext_s && (scan_code == 8'h14)) rctrl_r  <= is_make_s;
        end
    end

    // Stage register holding the translated character for one cycle.
    always_ff @(posedge clock_50) begin
        if (res) begin
            push_req_r  <= 1'b0;
            push_char_r <= 7'h00;
        end else begin
            push_req_r  <= push_s;
            push_char_r <= char_s;
        end
    end

`ifdef KBD_FIFO_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    logic [6:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
    logic [CW-1:0] count_r, count_nxt_s;
    logic          do_push_s, do_pop_s, drop_s;
    logic [7:0]    head_nxt_s;

    // FIFO control. A full FIFO still accepts a push when the head pops in the
    // same cycle. The next head is precomputed so that kbd can be a plain register.
    always_comb begin
        do_pop_s     = kbd_clr && (count_r != CNT_ZERO);
        do_push_s    = push_req_r && ((count_r != CNT_FULL) || do_pop_s);
        drop_s       = push_req_r && !do_push_s;
        rd_ptr_nxt_s = do_pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        if (count_nxt_s == CNT_ZERO) begin
            head_nxt_s = 8'h00;
        end else if (do_push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            // The character being written becomes the only entry.
            head_nxt_s = {1'b1, push_char_r};
        end else begin
            head_nxt_s = {1'b1, mem_r[rd_ptr_nxt_s]};
        end
    end

    // FIFO storage, pointers, keyboard register and sticky overflow.
    always_ff @(posedge clock_50) begin
        if (res) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_r[i] <= 7'h00;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= CNT_ZERO;
            kbd_r      <= 8'h00;
            overflow_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_char_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            kbd_r    <= head_nxt_s;
            if (drop_s) overflow_r <= 1'b1;
        end
    end
`else
    logic        drop_s;
    logic [7:0]  kbd_nxt_s;
    logic [31:0] depth_unused_s;

    // FIFO_DEPTH has no meaning for the single holding register.
    assign depth_unused_s = 32'(FIFO_DEPTH);

    // Single-entry holding register: a new character always wins. If an unread
    // character is lost, that is an overflow, except when it is popped in the same cycle.
    always_comb begin
        drop_s = push_req_r && kbd_r[7] && !kbd_clr;
        if (push_req_r) begin
            kbd_nxt_s = {1'b1, push_char_r};
        end else if (kbd_clr) begin
            kbd_nxt_s = 8'h00;
        end else begin
            kbd_nxt_s = kbd_r;
        end
    end

    // Keyboard register and sticky overflow.
    always_ff @(posedge clock_50) begin
        if (res) begin
            kbd_r      <= 8'h00;
            overflow_r <= 1'b0;
        end else begin
            kbd_r <= kbd_nxt_s;
            if (drop_s) overflow_r <= 1'b1;
        end
    end
`endif

    assign kbd      = kbd_r;
    assign kbd_strb = kbd_r[7];
    assign overflow = overflow_r;

endmodule

// File: doc/ps2_ascii_kbd.md
# ps2_ascii_kbd

Converts the raw PS/2 set-2 scan-code stream from the PS/2 receiver into 7-bit uppercase ASCII key presses and holds them for the 6502 in an Apple-II-style keyboard register. It sits between `ps2ctrlr` (upstream, byte producer) and `address_decode` (downstream), which reads `kbd` and pulses `kbd_clr` on a strobe-clear access. It tracks break/extended prefixes, Shift and Ctrl state, and buffers presses so fast typing is not lost.

## Interface
- `FIFO_DEPTH`, 4, number of buffered characters; power of two, 2..16.
- `clock_50`  in  1  system clock, 50 MHz; all logic on rising edge.
- `res`  in  1  synchronous, active-high reset.
- `scan_code`  in  8  byte from PS/2 receiver; sampled only when `scan_valid`=1.
- `scan_valid`  in  1  one-cycle pulse per received byte.
- `kbd_clr`  in  1  one-cycle pulse from address decode; pops the current character.
- `kbd`  out  8  bit7 = key available, bits6:0 = ASCII of FIFO head (0 when empty).
- `kbd_strb`  out  1  equals `kbd[7]`.
- `overflow`  out  1  sticky: a character was dropped because the FIFO was full.

## Operation
- Prefix FSM, states IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
  - IDLE: F0→BRK; E0→EXT; other byte = make code, translate, return IDLE.
  - BRK: any byte = break code; update modifiers only; →IDLE.
  - EXT: F0→EXT_BRK; other byte = extended make; →IDLE.
  - EXT_BRK: any byte = extended break, update modifiers; →IDLE.
- Modifiers: shift = L-Shift (12) or R-Shift (59) held; ctrl = L-Ctrl (14) or extended R-Ctrl (E0 14) held. Set on make, clear on break. Modifier make codes produce no character.
- Translation (make codes only):
  - Letters A–Z → 0x41–0x5A, regardless of shift.
  - Digits 0–9 → 0x30–0x39; with shift → US symbols (1→'!' 0x21, 2→'@' 0x40, ..., 0→')' 0x29).
  - Punctuation keys ` - = [ ] \ ; ' , . / → unshifted/shifted US ASCII.
  - Space 29→0x20, Enter 5A→0x0D, Backspace 66→0x08, Esc 76→0x1B, Tab 0D→0x09.
  - Extended: Left 6B→0x08, Right 74→0x15, keypad Enter 5A→0x0D; other extended codes dropped.
  - Ctrl held and result in 0x40–0x5F → result & 0x1F (Ctrl-C = 0x03).
  - Unmapped codes dropped, no push.
- FIFO: push on valid translation; pop on `kbd_clr` when non-empty. Full + push → char dropped, `overflow` set. Empty + `kbd_clr` → no effect.
- `overflow` clears only on `res`.

## Timing
- Reset: FSM IDLE, shift=ctrl=0, FIFO empty, `kbd`=0x00, `kbd_strb`=0, `overflow`=0.
- Cycle N: `scan_valid` with make code; N+1: FIFO written; N+2: `kbd` = {1, ascii} (empty FIFO case). Latency 2 cycles.
- `kbd_clr` at cycle M: head popped at M+1; `kbd` shows next char (bit7=1) or 0x00 at M+1.
- Simultaneous push and pop: both performed, occupancy unchanged; full + simultaneous pop accepts the push (no overflow).
- Back-to-back `scan_valid` on consecutive cycles fully supported.
- `res` overrides all other inputs in the same cycle; a partial prefix sequence is discarded.
- `kbd` registered; no combinational path from inputs to outputs.

## Configuration
- `KBD_FIFO_EN` defined: FIFO of `FIFO_DEPTH` entries as above.
- Undefined: single-entry latch; a new character overwrites an unread one and sets `overflow`; `FIFO_DEPTH` ignored. Latency and `kbd_clr` behaviour unchanged.

## Test plan
- Reset, then bytes 1C → `kbd`=0xC1 ('A') two cycles later; F0 1C → no change; `kbd_clr` → `kbd`=0x00.
- 12, 16, F0 12 (Shift+1) → `kbd`=0xA1 ('!'); then 16 after release → next char 0xB1.
- 14, 21 (Ctrl+C) → 0x83; E0 6B → 0x88; E0 7D (unmapped) → no push.
- With `KBD_FIFO_EN`, depth 4: five presses without clear → 4 chars pop in order, `overflow`=1; without macro → only last char read, `overflow`=1.
- Full FIFO, push and `kbd_clr` same cycle → head advances, new char accepted, `overflow` stays 0.
- Assert `res` after E0 F0 → following byte 1C treated as make → 0xC1; shift state cleared.
